// File: rtl/vga_sync_receiver_if.sv
// Bundles the pixel/sync input stream and the recovered-pixel outputs of vga_sync_receiver.
// master drives the sync stream; slave is the receiver.
interface vga_sync_receiver_if;
    logic        pix_en;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  pixel_in;
    logic [7:0]  pixel_out;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        pixel_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output pix_en, hsync_in, vsync_in, pixel_in,
        input  pixel_out, hcount, vcount, pixel_valid, frame_start,
               locked, sync_err, frame_cnt, err_cnt
    );

    modport slave (
        input  pix_en, hsync_in, vsync_in, pixel_in,
        output pixel_out, hcount, vcount, pixel_valid, frame_start,
               locked, sync_err, frame_cnt, err_cnt
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers raw line/column position from hsync/vsync and delivers active pixels
// once a full frame matching the timing parameters has been seen. VGA_RX_STATS_EN adds frame/error counters.
module vga_sync_receiver #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_sync_receiver_if.slave bus
);
    localparam logic [1:0]  ST_UNLOCKED = 2'd0;
    localparam logic [1:0]  ST_ARMED    = 2'd1;
    localparam logic [1:0]  ST_LOCKED   = 2'd2;
    localparam logic [9:0]  RAW_MAX     = 10'd1023;
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_LO        = 10'(H_START);
    localparam logic [9:0]  V_LO        = 10'(V_START);
    localparam logic [10:0] H_END       = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_END       = 11'(V_START + V_ACTIVE);

    logic       hsPrev_q, vsPrev_q, sample_q;
    logic [7:0] pix_q;
    logic [9:0] hraw_q, hraw_d;
    logic [9:0] vraw_q, vraw_d;
    logic [1:0] state_q, state_d;
    logic       frameBad_q, frameBad_d;
    logic       syncErr_q, syncErr_d;
    logic [7:0] pixelOut_q;
    logic [9:0] hcount_q, vcount_q;
    logic       pixelValid_q, frameStart_q;
    logic       hFall, vFall, lineBad, frameGood;
    logic       active, deliver, firstPixel;

    assign hFall     = hsPrev_q & ~bus.hsync_in;
    assign vFall     = vsPrev_q & ~bus.vsync_in;
    assign lineBad   = hFall && (hraw_q != H_LAST);
    // A line ending on the same sample as the frame still belongs to that frame.
    assign frameGood = (vraw_q == V_LAST) && !frameBad_q && !lineBad;

    always_comb begin
        hraw_d     = hraw_q;
        vraw_d     = vraw_q;
        state_d    = state_q;
        frameBad_d = frameBad_q;
        syncErr_d  = 1'b0;
        if (bus.pix_en) begin
            if (hFall)
                hraw_d = '0;
            else if (hraw_q != RAW_MAX)
                hraw_d = hraw_q + 10'd1;
            if (vFall)
                vraw_d = '0;
            else if (hFall && (vraw_q != RAW_MAX))
                vraw_d = vraw_q + 10'd1;
            frameBad_d = vFall ? 1'b0 : (frameBad_q | lineBad);
            case (state_q)
                ST_UNLOCKED: if (vFall) state_d = ST_ARMED;
                ST_ARMED:    if (vFall && frameGood) state_d = ST_LOCKED;
                ST_LOCKED: begin
                    if (lineBad || (vFall && !frameGood) || (hraw_d == RAW_MAX)) begin
                        state_d   = ST_UNLOCKED;
                        syncErr_d = 1'b1;
                    end
                end
                default:     state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsPrev_q   <= 1'b1;
            vsPrev_q   <= 1'b1;
            pix_q      <= '0;
            sample_q   <= 1'b0;
            hraw_q     <= '0;
            vraw_q     <= '0;
            state_q    <= ST_UNLOCKED;
            frameBad_q <= 1'b0;
            syncErr_q  <= 1'b0;
        end else begin
            sample_q   <= bus.pix_en;
            hraw_q     <= hraw_d;
            vraw_q     <= vraw_d;
            state_q    <= state_d;
            frameBad_q <= frameBad_d;
            syncErr_q  <= syncErr_d;
            if (bus.pix_en) begin
                hsPrev_q <= bus.hsync_in;
                vsPrev_q <= bus.vsync_in;
                pix_q    <= bus.pixel_in;
            end
        end
    end

    // Delivery looks at the sample taken on the previous edge, so it sees the state that sample produced.
    assign active     = (hraw_q >= H_LO) && ({1'b0, hraw_q} < H_END) &&
                        (vraw_q >= V_LO) && ({1'b0, vraw_q} < V_END);
    assign deliver    = sample_q && active && (state_q == ST_LOCKED);
    assign firstPixel = (hraw_q == H_LO) && (vraw_q == V_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelOut_q   <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            pixelValid_q <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            pixelValid_q <= deliver;
            frameStart_q <= deliver && firstPixel;
            if (deliver) begin
                pixelOut_q <= pix_q;
                hcount_q   <= hraw_q - H_LO;
                vcount_q   <= vraw_q - V_LO;
            end
        end
    end

    assign bus.pixel_out   = pixelOut_q;
    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.pixel_valid = pixelValid_q;
    assign bus.frame_start = frameStart_q;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.sync_err    = syncErr_q;

`ifdef VGA_RX_STATS_EN
    logic [15:0] frameCnt_q;
    logic [7:0]  errCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else begin
            if (deliver && firstPixel)
                frameCnt_q <= frameCnt_q + 16'd1;
            if (syncErr_d && (errCnt_q != 8'hFF))
                errCnt_q <= errCnt_q + 8'd1;
        end
    end

    assign bus.frame_cnt = frameCnt_q;
    assign bus.err_cnt   = errCnt_q;
`else
    assign bus.frame_cnt = '0;
    assign bus.err_cnt   = '0;
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a scaled-down 20x12 timing and a sample-level reference model.
`timescale 1ns/1ps
module tb_vga_sync_receiver;
    localparam int HT = 20;
    localparam int HS = 4;
    localparam int HA = 12;
    localparam int VT = 12;
    localparam int VS = 3;
    localparam int VA = 6;
`ifdef VGA_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    vga_sync_receiver_if bus();

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int minGap = 1;
    int maxGap = 1;
    int strobeCnt = 0;
    int errPulses = 0;
    bit captureFirst = 0;
    bit gotFirst = 0;
    int firstHc, firstVc, firstPix, firstFs;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: raw position counters, line/frame goodness and lock status per sample.
    int         mH, mV, mBad, mNh, mNv;
    bit         mHsPrev, mVsPrev, mArmed, mLock, mHf, mVf, mFrameGood;
    bit         pend, pendFs;
    logic [7:0] pendPix;
    int         pendHc, pendVc;
    bit         expValid, expFs, expErr;
    logic [7:0] expPix;
    int         expHc, expVc, expFrameCnt, expErrCnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mH = 0; mV = 0; mBad = 0; mHsPrev = 1; mVsPrev = 1; mArmed = 0; mLock = 0;
            pend = 0; pendFs = 0; pendPix = 0; pendHc = 0; pendVc = 0;
            expValid = 0; expFs = 0; expErr = 0; expPix = 0; expHc = 0; expVc = 0;
            expFrameCnt = 0; expErrCnt = 0;
        end else begin
            expValid = pend;
            expFs    = pend && pendFs;
            expErr   = 0;
            if (pend) begin
                expPix = pendPix; expHc = pendHc; expVc = pendVc;
                if (pendFs) expFrameCnt = (expFrameCnt + 1) % 65536;
            end
            pend = 0;
            if (bus.pix_en) begin
                mHf = mHsPrev && !bus.hsync_in;
                mVf = mVsPrev && !bus.vsync_in;
                if (mHf && mH != HT - 1) mBad++;
                mFrameGood = (mV == VT - 1) && (mBad == 0);
                mNh = mHf ? 0 : ((mH < 1023) ? mH + 1 : 1023);
                mNv = mVf ? 0 : (mHf ? ((mV < 1023) ? mV + 1 : 1023) : mV);
                if (mLock) begin
                    if ((mHf && mH != HT - 1) || (mVf && !mFrameGood) || mNh == 1023) begin
                        mLock = 0; mArmed = 0; expErr = 1;
                        if (expErrCnt < 255) expErrCnt++;
                    end
                end else if (mVf) begin
                    mLock  = mArmed && mFrameGood;
                    mArmed = 1;
                end
                if (mVf) mBad = 0;
                mH = mNh; mV = mNv;
                mHsPrev = bus.hsync_in; mVsPrev = bus.vsync_in;
                if (mLock && mH >= HS && mH < HS + HA && mV >= VS && mV < VS + VA) begin
                    pend = 1; pendPix = bus.pixel_in;
                    pendHc = mH - HS; pendVc = mV - VS;
                    pendFs = (pendHc == 0) && (pendVc == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("pixel_valid", bus.pixel_valid, expValid);
        checkOutput("frame_start", bus.frame_start, expFs);
        checkOutput("sync_err", bus.sync_err, expErr);
        checkOutput("locked", bus.locked, mLock);
        checkOutput("pixel_out", bus.pixel_out, expPix);
        checkOutput("hcount", bus.hcount, expHc);
        checkOutput("vcount", bus.vcount, expVc);
        checkOutput("frame_cnt", bus.frame_cnt, STATS ? expFrameCnt : 0);
        checkOutput("err_cnt", bus.err_cnt, STATS ? expErrCnt : 0);
        if (bus.pixel_valid) begin
            strobeCnt++;
            if (captureFirst && !gotFirst) begin
                gotFirst = 1;
                firstHc = bus.hcount; firstVc = bus.vcount;
                firstPix = bus.pixel_out; firstFs = bus.frame_start;
            end
        end
        if (bus.sync_err) errPulses++;
    end

    // Gap cycles carry random sync/pixel values that must be ignored.
    task automatic applyStimulus(input logic h, input logic v, input logic [7:0] p);
        int gap = $urandom_range(maxGap, minGap);
        repeat (gap) begin
            @(posedge clk); #1;
            bus.pix_en   = 1'b0;
            bus.hsync_in = 1'($urandom);
            bus.vsync_in = 1'($urandom);
            bus.pixel_in = 8'($urandom);
        end
        @(posedge clk); #1;
        bus.pix_en = 1'b1; bus.hsync_in = h; bus.vsync_in = v; bus.pixel_in = p;
    endtask

    task automatic sendFrame(input int nLines, input int badIdx, input int badLen, input bit pixByLine);
        for (int ln = 0; ln < nLines; ln++) begin
            int len = (ln == badIdx) ? badLen : HT;
            for (int s = 0; s < len; s++)
                applyStimulus(s >= 2, ln >= 2, pixByLine ? 8'(ln) : 8'($urandom));
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.pix_en = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.pix_en = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.pixel_in = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetLocked", bus.locked, 0);
        checkOutput("resetValid", bus.pixel_valid, 0);
        checkOutput("resetFrameCnt", bus.frame_cnt, 0);
        rst_n = 1'b1;

        $display("[TB] nominal frames, pix_en every other clock");
        sendFrame(VT, -1, 0, 1'b1);
        idleCycles(2);
        checkOutput("lockedAfterFirstFrame", bus.locked, 0);
        strobeCnt = 0; captureFirst = 1;
        sendFrame(VT, -1, 0, 1'b1);
        idleCycles(2);
        checkOutput("lockedAfterSecondFall", bus.locked, 1);
        checkOutput("strobesFrame2", strobeCnt, 72);
        checkOutput("firstStrobeSeen", gotFirst, 1);
        checkOutput("firstHcount", firstHc, 0);
        checkOutput("firstVcount", firstVc, 0);
        checkOutput("firstPixel", firstPix, 3);
        checkOutput("firstFrameStart", firstFs, 1);
        strobeCnt = 0;
        sendFrame(VT, -1, 0, 1'b1);
        idleCycles(2);
        checkOutput("strobesFrame3", strobeCnt, 72);

        $display("[TB] reset in the middle of a locked frame");
        sendFrame(7, -1, 0, 1'b1);
        @(posedge clk); #1;
        bus.pix_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetLocked", bus.locked, 0);
        checkOutput("asyncResetPixel", bus.pixel_out, 0);
        checkOutput("asyncResetHcount", bus.hcount, 0);
        checkOutput("asyncResetVcount", bus.vcount, 0);
        checkOutput("asyncResetValid", bus.pixel_valid, 0);
        checkOutput("asyncResetErrCnt", bus.err_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        minGap = 0; maxGap = 3;
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(2);
        checkOutput("lockedAfterResetFrame1", bus.locked, 0);
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(2);
        checkOutput("relockedAfterTwoFalls", bus.locked, 1);
        sendFrame(VT, -1, 0, 1'b0);

        $display("[TB] short line while locked");
        errPulses = 0; strobeCnt = 0;
        sendFrame(VT, 1, HT - 1, 1'b0);
        idleCycles(2);
        checkOutput("shortLineSyncErr", errPulses, 1);
        checkOutput("lockedAfterShortLine", bus.locked, 0);
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(2);
        checkOutput("strobesWhileRelocking", strobeCnt, 0);
        strobeCnt = 0;
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(2);
        checkOutput("strobesAfterRelock", strobeCnt, 72);

        $display("[TB] hsync held high past saturation");
        errPulses = 0;
        sendFrame(VT, 1, 1102, 1'b0);
        idleCycles(2);
        checkOutput("saturationSyncErr", errPulses, 1);
        checkOutput("lockedAfterSaturation", bus.locked, 0);
        sendFrame(VT, -1, 0, 1'b0);
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(2);
        checkOutput("lockedAfterRecovery", bus.locked, 1);
        checkOutput("statsFrameCnt", bus.frame_cnt, STATS ? 4 : 0);
        checkOutput("statsErrCnt", bus.err_cnt, STATS ? 2 : 0);

        $display("[TB] frame with too few lines");
        errPulses = 0;
        sendFrame(VT - 1, -1, 0, 1'b0);
        sendFrame(VT, -1, 0, 1'b0);
        idleCycles(4);
        checkOutput("shortFrameSyncErr", errPulses, 1);
        checkOutput("lockedAfterShortFrame", bus.locked, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
